// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner select,
// and the starvation-counter width helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Bits needed to hold 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the arbiter: CPU has priority unless DMA has lost
// STARVE_MAX consecutive conflicts, in which case DMA wins the next one.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   arb_en,
  output logic   grant,
  output owner_t winner
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    winner = OWN_CPU;
    if (dma_req && (!cpu_req || starve_cnt >= MAX_CNT)) begin
      winner = OWN_DMA;
    end
  end

  assign grant = arb_en & (cpu_req | dma_req);

  // Only conflicts won by the CPU count toward DMA starvation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (winner == OWN_DMA) begin
        starve_cnt <= '0;
      end else if (dma_req && starve_cnt != MAX_CNT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and a DMA/debug port.
// Every access runs IDLE -> ACCESS -> RESP, so one access per three cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nx;
  owner_t            owner;
  owner_t            winner;
  logic              grant;
  logic              idle;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  assign idle = (state == IDLE);

  dmem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .arb_en (idle),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner <= winner;
        if (winner == OWN_DMA) begin
          lat_we    <= dma_we;
          lat_addr  <= dma_addr;
          lat_wdata <= dma_wdata;
        end else begin
          lat_we    <= cpu_we;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
        end
      end
      // Read data is captured from the combinational memory at the end of ACCESS.
      if (state == ACCESS && !lat_we) begin
        if (owner == OWN_DMA) dma_rdata <= mem_rdata;
        else                  cpu_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_we    = (state == ACCESS) & lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    cpu_ack   = (state == RESP) & (owner == OWN_CPU);
    dma_ack   = (state == RESP) & (owner == OWN_DMA);
    cpu_stall = cpu_req & ~cpu_ack;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a word-addressed memory model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ack, cpu_stall, dma_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .cpu_stall(cpu_stall),
    .dma_req  (dma_req),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata),
    .dma_ack  (dma_ack),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic dma, output int cycles);
    cycles = 0;
    while (((dma ? dma_ack : cpu_ack) !== 1'b1) && cycles < 10) begin
      step();
      cycles++;
    end
    checks++;
    if ((dma ? dma_ack : cpu_ack) !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout dma=%0b: no ack within 10 cycles, required ack=1", dma);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (u_dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", u_dut.state); end
    checks++; if ({cpu_ack, dma_ack, mem_we, cpu_stall} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {cpu_ack, dma_ack, mem_we, cpu_stall}); end
    checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", cpu_rdata, dma_rdata); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_latch got %h/%h want 0/0", mem_addr, mem_wdata); end
    checks++; if (u_dut.u_pick.starve_cnt !== 3'd0) begin errors++; $display("FAIL reset_starve got %0d want 0", u_dut.u_pick.starve_cnt); end
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h64; cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_stall_n got %b want 1", cpu_stall); end
    step();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h64 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_access got we=%b addr=%h data=%h want 1/64/deadbeef", mem_we, mem_addr, mem_wdata); end
    checks++; if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL wr_n1 got ack=%b stall=%b want 0/1", cpu_ack, cpu_stall); end
    step();
    checks++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_ack got cack=%b dack=%b we=%b want 1/0/0", cpu_ack, dma_ack, mem_we); end
    cpu_req = 0;
    step();
    checks++; if (mem[25] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_commit got %h want deadbeef", mem[25]); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", cpu_ack); end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h64; cpu_wdata = '0;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_n got %b want 1", cpu_stall); end
    step();
    checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_stall_n1 got stall=%b we=%b want 1/0", cpu_stall, mem_we); end
    step();
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rd_data got ack=%b rdata=%h stall=%b want 1/deadbeef/0", cpu_ack, cpu_rdata, cpu_stall); end
    cpu_req = 0;
    step();
  endtask

  task automatic test_dma();
    int cyc;
    dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h11;
    wait_ack(1'b1, cyc);
    checks++; if (cyc !== 2 || cpu_ack !== 1'b0) begin errors++; $display("FAIL dma_wr_lat got %0d cack=%b want 2/0", cyc, cpu_ack); end
    dma_req = 0;
    step();
    dma_req = 1; dma_we = 0;
    wait_ack(1'b1, cyc);
    checks++; if (dma_rdata !== 32'h11) begin errors++; $display("FAIL dma_rdata got %h want 11", dma_rdata); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dma_cpu_rdata got %h want deadbeef", cpu_rdata); end
    dma_req = 0;
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'hA5A50001;
    wait_ack(1'b0, cyc);
    cpu_we = 0;
    step();
    checks++; if (u_dut.state !== IDLE || cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_idle got st=%0d ack=%b want 0/0", u_dut.state, cpu_ack); end
    step();
    checks++; if (u_dut.state !== ACCESS) begin errors++; $display("FAIL b2b_access got %0d want 1", u_dut.state); end
    step();
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hA5A50001) begin
      errors++; $display("FAIL b2b_ack got ack=%b rdata=%h want 1/a5a50001", cpu_ack, cpu_rdata); end
    cpu_req = 0;
    step();
  endtask

  task automatic test_starvation();
    int n;
    logic exp_dma;
    int exp_cnt;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h64;
    dma_req = 1; dma_we = 0; dma_addr = 32'h80;
    for (int g = 0; g < 10; g++) begin
      exp_dma = ((g % 5) == 4);
      exp_cnt = exp_dma ? 0 : (g % 5) + 1;
      n = 0;
      while (!(cpu_ack === 1'b1 || dma_ack === 1'b1) && n < 10) begin step(); n++; end
      checks++; if (dma_ack !== exp_dma || cpu_ack !== !exp_dma) begin
        errors++; $display("FAIL starve_order grant %0d got cack=%b dack=%b want dma=%b", g, cpu_ack, dma_ack, exp_dma); end
      checks++; if (u_dut.u_pick.starve_cnt !== 3'(exp_cnt)) begin
        errors++; $display("FAIL starve_cnt grant %0d got %0d want %0d", g, u_dut.u_pick.starve_cnt, exp_cnt); end
      step();
    end
    cpu_req = 0; dma_req = 0;
    step();
    checks++; if (cpu_rdata !== 32'hDEADBEEF || dma_rdata !== 32'h11) begin
      errors++; $display("FAIL starve_rdata got %h/%h want deadbeef/11", cpu_rdata, dma_rdata); end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h200; cpu_wdata = 32'h55;
    step();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got we=%b want 1", mem_we); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || u_dut.state !== IDLE) begin errors++; $display("FAIL rst_mid_async got we=%b st=%0d want 0/0", mem_we, u_dut.state); end
    checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got %h/%h want 0/0", cpu_rdata, dma_rdata); end
    cpu_req = 0;
    step();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ack === 1'b1 || dma_ack === 1'b1) acks++;
      step();
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_noack got %0d acks want 0", acks); end
    checks++; if (mem[128] !== 32'h0) begin errors++; $display("FAIL rst_mid_nowrite got %h want 0", mem[128]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_dma();
    test_back_to_back();
    test_starvation();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store port and a second requester: DMA / debug loader.
- Sits between `cpu`/DMA and `dmem` at top level. Replaces the direct `cpu`→`dmem` connection.
- Each requester uses a req/ack handshake. The block sequences every access through a 3-state FSM.
- CPU has priority; a starvation counter guarantees DMA progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive CPU-won conflicts after which DMA wins the next conflict (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  CPU write enable (1 = store).
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational); drives pipeline stall.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as the CPU signals, for DMA.
- mem_we  out  1  dmem write enable.
- mem_addr  out  ADDR_W  dmem address.
- mem_wdata  out  DATA_W  dmem write data.
- mem_rdata  in  DATA_W  dmem combinational read data.

Behaviour:
- Reset values:
  - state = IDLE; owner = CPU.
  - starve_cnt = 0.
  - latched addr, wdata and we = 0.
  - cpu_rdata = dma_rdata = 0.
  - both acks = 0; mem_we = 0.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant CPU if starve_cnt < STARVE_MAX, else grant DMA.
  - On grant, latch owner, we, addr and wdata, then go to ACCESS.
- starve_cnt update:
  - Conflict won by CPU: starve_cnt increments, saturating at STARVE_MAX.
  - Any DMA grant: starve_cnt clears to 0.
  - CPU grant with no conflict: starve_cnt unchanged.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we.
  - The write commits at the closing edge.
  - On a read, at the closing edge mem_rdata is registered into the owner's rdata. On a write, the owner's rdata is unchanged.
  - Next state is RESP.
- RESP (1 cycle):
  - Owner's ack = 1 and rdata is valid.
  - Requests are ignored in this cycle.
  - Next state is always IDLE.
- Requester rules:
  - Request fields must stay stable while req is high.
  - Drop req, or present a new request, on the edge that ends the ack cycle.
- Latency and throughput:
  - Request seen in IDLE at cycle N → ACCESS at N+1 → ack at N+2.
  - Peak throughput is 1 access per 3 cycles.
- Outside ACCESS: mem_we = 0; mem_addr and mem_wdata hold the latched values.
- rdata registers hold their value until that requester's next read completes.
- Addresses and data pass unmodified (no alignment check).
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
  - A write in ACCESS may not commit.
  - No ack is issued; the requester re-issues after reset.
- A requester dropping req before ack is illegal; the arbiter still completes the latched access.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - owner encoding OWN_CPU=1'b0, OWN_DMA=1'b1.
- One sub-module, dmem_arb_pick: combinational winner selection plus the saturating starve_cnt register.

Test Plan:
- Single CPU write:
  - Stimulus: cpu_req=1, cpu_we=1, addr=0x64, wdata=0xDEADBEEF.
  - Response: mem_we=1 for one cycle with those values; cpu_ack at N+2; dma_ack stays 0.
- CPU read-back:
  - Stimulus: read addr 0x64.
  - Response: cpu_rdata=0xDEADBEEF when cpu_ack=1; cpu_stall high for cycles N, N+1.
- Both requesting continuously (STARVE_MAX=4):
  - Response: grant order CPU,CPU,CPU,CPU,DMA, then repeating; starve_cnt returns to 0 after each DMA grant.
- DMA alone:
  - Stimulus: DMA writes 0x0000_0011 to addr 0x80, then reads it back.
  - Response: dma_rdata=0x11 on the second dma_ack; cpu_rdata unchanged.
- Back-to-back:
  - Stimulus: a new CPU request presented on the ack edge.
  - Response: next ACCESS 2 cycles later; acks exactly 3 cycles apart.
- Reset during ACCESS of a write:
  - Response: mem_we falls immediately; no ack; state = IDLE; both rdata = 0.
